// File: rtl/fetch_ctrl.sv
// Fetch sequencer: owns the fetch PC, drives imem req/ack and the F/D slot.
// Optional ack-timeout flag via FETCH_TIMEOUT_EN.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'h0000_3000,
    parameter int          MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        pc_en,
    output logic [31:0] pc_next,
    output logic        if_valid,
    output logic [31:0] if_instr,
    output logic [31:0] if_pc,
    output logic        fetch_err
);

    typedef enum logic [1:0] {IDLE, REQ, HOLD} state_t;

    state_t      state, state_nx;
    logic [31:0] fpc, fpc_nx;
    logic [31:0] tgt, tgt_nx;
    logic [31:0] skid_instr, skid_instr_nx;
    logic [31:0] skid_pc, skid_pc_nx;
    logic        pend, pend_nx;
    logic        dslot, dslot_nx;
    logic        valid_nx;
    logic [31:0] instr_nx, ifpc_nx;
    logic        slot_free, redir;
    logic [31:0] seq_pc;

    assign slot_free = !if_valid || !stall;
    assign redir     = redirect && !stall;
    assign seq_pc    = fpc + 32'd4;
    assign imem_req  = (state == REQ);
    assign imem_addr = fpc;
    assign pc_next   = fpc_nx;

    always_comb begin
        state_nx      = state;
        fpc_nx        = fpc;
        tgt_nx        = tgt;
        pend_nx       = pend;
        dslot_nx      = dslot;
        skid_instr_nx = skid_instr;
        skid_pc_nx    = skid_pc;
        instr_nx      = if_instr;
        ifpc_nx       = if_pc;
        valid_nx      = if_valid && !slot_free;
        pc_en         = 1'b0;
        unique case (state)
            IDLE: begin
                state_nx = REQ;
                if (redir) begin
                    tgt_nx = redirect_pc;
                    if (if_valid) pend_nx = 1'b1;
                    else dslot_nx = 1'b1;
                end
            end
            REQ: begin
                if (imem_ack) begin
                    pc_en = 1'b1;
                    if (pend) begin
                        fpc_nx  = tgt;
                        pend_nx = 1'b0;
                    end else if (redir && if_valid) begin
                        fpc_nx = redirect_pc;
                    end else begin
                        // This ack may itself be the delay slot
                        if (dslot) fpc_nx = tgt;
                        else if (redir) fpc_nx = redirect_pc;
                        else fpc_nx = seq_pc;
                        dslot_nx = 1'b0;
                        if (slot_free) begin
                            instr_nx = imem_rdata;
                            ifpc_nx  = fpc;
                            valid_nx = 1'b1;
                        end else begin
                            skid_instr_nx = imem_rdata;
                            skid_pc_nx    = fpc;
                            state_nx      = HOLD;
                        end
                    end
                end else if (redir) begin
                    tgt_nx = redirect_pc;
                    if (if_valid) pend_nx = 1'b1;
                    else dslot_nx = 1'b1;
                end
            end
            HOLD: begin
                if (!stall) begin
                    state_nx = REQ;
                    if (redirect) begin
                        pc_en  = 1'b1;
                        fpc_nx = redirect_pc;
                    end else begin
                        instr_nx = skid_instr;
                        ifpc_nx  = skid_pc;
                        valid_nx = 1'b1;
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state      <= IDLE;
            fpc        <= RESET_PC;
            tgt        <= RESET_PC;
            pend       <= 1'b0;
            dslot      <= 1'b0;
            skid_instr <= 32'd0;
            skid_pc    <= RESET_PC;
            if_valid   <= 1'b0;
            if_instr   <= 32'd0;
            if_pc      <= RESET_PC;
        end else begin
            state      <= state_nx;
            fpc        <= fpc_nx;
            tgt        <= tgt_nx;
            pend       <= pend_nx;
            dslot      <= dslot_nx;
            skid_instr <= skid_instr_nx;
            skid_pc    <= skid_pc_nx;
            if_valid   <= valid_nx;
            if_instr   <= instr_nx;
            if_pc      <= ifpc_nx;
        end
    end

`ifdef FETCH_TIMEOUT_EN
    localparam int CW = $clog2(MAX_WAIT + 1);

    logic [CW-1:0] wait_cnt;
    logic          err_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            wait_cnt <= '0;
            err_q    <= 1'b0;
        end else if (state == REQ && !imem_ack) begin
            if (wait_cnt != CW'(MAX_WAIT)) wait_cnt <= wait_cnt + 1'b1;
            if (wait_cnt == CW'(MAX_WAIT - 1)) err_q <= 1'b1;
        end else begin
            wait_cnt <= '0;
        end
    end

    assign fetch_err = err_q;
`else
    assign fetch_err = 1'b0;
`endif

endmodule

// File: doc/fetch_ctrl.md
Name: fetch_ctrl

Overview:
- Fetch sequencer in front of the IF-stage PC register. It owns the fetch address and drives a req/ack instruction-memory port.
- Delivers one instruction per cycle into the F/D boundary, and drives the IFU's enable/next_pc so the architectural PC tracks the fetch stream.
- Handles downstream stall with a one-entry skid buffer, and branch/jump redirect with MIPS delay-slot semantics.

Parameters:
- RESET_PC, 32'h0000_3000, first fetch address after reset.
- MAX_WAIT, 16, ack-timeout threshold in cycles (used only with FETCH_TIMEOUT_EN).

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  synchronous, active-low reset.
- stall  in  1  D stage cannot accept; if_* must hold.
- redirect  in  1  taken branch/jump from D stage.
- redirect_pc  in  32  target address.
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address.
- imem_ack  in  1  one-cycle response strobe.
- imem_rdata  in  32  instruction; valid with imem_ack.
- pc_en  out  1  IFU enable.
- pc_next  out  32  IFU next_pc.
- if_valid  out  1  if_instr/if_pc hold a valid instruction.
- if_instr  out  32  fetched instruction.
- if_pc  out  32  address of if_instr.
- fetch_err  out  1  ack timeout flag (sticky).

Behaviour:
- Reset (reset==0 at posedge): state=IDLE, fpc=RESET_PC, if_valid=0, if_instr=0, if_pc=RESET_PC, skid empty, pend/dslot flags 0, fetch_err=0.
- Reset outputs: imem_req=0, imem_addr=RESET_PC, pc_en=0, pc_next=RESET_PC.
- Reset mid-request abandons the request. Memory must drop it.
- States:
  - IDLE: one cycle, then REQ.
  - REQ: imem_req=1.
  - HOLD: imem_req=0; skid full.
- Request rules:
  - imem_addr=fpc at all times.
  - Once imem_req rises, imem_req and imem_addr stay stable until the ack cycle.
  - Ack is accepted only in REQ; ack in IDLE/HOLD is ignored.
- Consume: slot_free = !if_valid || !stall.
- Ack in REQ, sequential case: fpc<=fpc+4 with pc_en=1, pc_next=fpc+4 (combinational, same cycle).
  - If slot_free: if_instr<=imem_rdata, if_pc<=fpc, if_valid<=1, stay REQ. Back-to-back acks give 1 instr/cycle.
  - Else: skid<=rdata/fpc, go HOLD.
- Output drain: if_valid cleared when slot_free and nothing is loaded that cycle.
- HOLD, stall==0: if_*<=skid, if_valid<=1, go REQ (first new request the next cycle).
- Redirect is sampled only when stall==0; it is ignored while stall==1.
- Redirect semantics: the delay slot (next sequential instruction after the branch) is always delivered. All later sequential fetches are discarded. Fetch resumes at redirect_pc.
- Redirect with if_valid==1: the presented instr is the delay slot and is consumed this cycle.
  - REQ + ack same cycle: rdata discarded, fpc<=redirect_pc, pc_en=1.
  - REQ, no ack: pend<=1, tgt<=redirect_pc. On the next ack, data is discarded and fpc<=tgt.
  - HOLD: skid discarded, fpc<=redirect_pc, go REQ.
- Redirect with if_valid==0: the delay slot is still outstanding. dslot<=1, tgt<=redirect_pc.
  - The next ack is delivered normally.
  - In that ack cycle fpc<=tgt instead of fpc+4, and dslot<=0.
- A second redirect while pend/dslot is set is a protocol violation; the later one overwrites tgt.
- Arithmetic: fpc+4 is 32-bit and wraps 0xFFFF_FFFC -> 0x0000_0000. No alignment check.
- pc_en is high exactly on cycles fpc changes; otherwise pc_en=0 and pc_next=fpc.

Optional Feature:
- Macro FETCH_TIMEOUT_EN.
- Defined:
  - A counter counts consecutive REQ cycles without ack and clears on ack or state change.
  - When the count reaches MAX_WAIT, fetch_err<=1, sticky until reset.
  - Fetch keeps waiting.
- Undefined: no counter; fetch_err tied 0.

Test Plan:
- Reset low 2 cycles, release, ack every cycle from cycle 2 -> if_pc sequence 0x3000, 0x3004, 0x3008, if_valid continuous; pc_en pulses with pc_next 0x3004, 0x3008...
- Ack latency 3 cycles -> imem_req/imem_addr=0x3000 stable for 3 cycles, if_valid low until the ack cycle+1.
- stall=1 for 4 cycles while ack returns 0x3004 -> if_* hold 0x3000, state HOLD with imem_req=0; after stall drops, if_pc=0x3004, then request 0x3008.
- redirect to 0x3100 while if_pc=0x3004 presented and 0x3008 in flight -> 0x3004 consumed, 0x3008 data discarded, next delivered if_pc=0x3100.
- redirect to 0x3200 with if_valid=0 -> next ack (0x300C) delivered as the delay slot, the following fetch is 0x3200.
- With FETCH_TIMEOUT_EN, MAX_WAIT=16, no ack -> fetch_err rises after 16 REQ cycles, stays 1 after a late ack, clears only on reset.
